// File: rtl/bp_be_dual_retire_ctrl_if.sv
// Calculator-to-retire bundle for the dual-lane retire controller.
// Lane 0 is the older instruction and lane 1 is the younger one.
interface bp_be_dual_retire_ctrl_if #(
    parameter int dpath_width_p     = 64,
    parameter int exception_width_p = 8,
    parameter int special_width_p   = 4
);
    logic                                flush_i;
    logic [1:0]                          v_i;
    logic [1:0]                          queue_v_i;
    logic [1:0][exception_width_p-1:0]   exception_i;
    logic [1:0][exception_width_p-1:0]   exception_late_i;
    logic [1:0][special_width_p-1:0]     special_i;
    logic [1:0][dpath_width_p-1:0]       data_i;

    logic [1:0]                          retire_v_o;
    logic [1:0]                          retire_queue_v_o;
    logic [1:0][exception_width_p-1:0]   retire_exception_o;
    logic [1:0][special_width_p-1:0]     retire_special_o;
    logic [1:0][dpath_width_p-1:0]       retire_data_o;
    logic                                squash_o;

    modport master (
        output flush_i, v_i, queue_v_i, exception_i, exception_late_i, special_i, data_i,
        input  retire_v_o, retire_queue_v_o, retire_exception_o, retire_special_o,
               retire_data_o, squash_o
    );

    modport slave (
        input  flush_i, v_i, queue_v_i, exception_i, exception_late_i, special_i, data_i,
        output retire_v_o, retire_queue_v_o, retire_exception_o, retire_special_o,
               retire_data_o, squash_o
    );
endinterface

// File: rtl/bp_be_dual_retire_ctrl.sv
// Dual-lane retire alignment pipe with in-order squash of the younger lane.
// Define BP_BE_RETIRE_STATS_EN to add the pair/single/squash retire counters.
module bp_be_dual_retire_ctrl #(
    parameter int retire_depth_p     = 2,
    parameter int dpath_width_gp     = 64,
    parameter int exception_width_lp = 8,
    parameter int special_width_lp   = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    bp_be_dual_retire_ctrl_if.slave io
`ifdef BP_BE_RETIRE_STATS_EN
    ,
    output logic [31:0] stat_pair_o,
    output logic [31:0] stat_single_o,
    output logic [31:0] stat_squash_o
`endif
);
    localparam int last_lp = retire_depth_p - 1;

    typedef struct packed {
        logic [1:0]                          v;
        logic [1:0]                          queue_v;
        logic [1:0][exception_width_lp-1:0]  exception;
        logic [1:0][special_width_lp-1:0]    special;
        logic [1:0][dpath_width_gp-1:0]      data;
    } entry_s;

    entry_s [retire_depth_p-1:0]          pipe_q, pipe_d;
    entry_s                               out_s;
    logic [1:0][exception_width_lp-1:0]   exc_eff;
    logic [1:0]                           redir;
    logic [1:0]                           retire_v;
    logic                                 red0, squash, kill;

    assign out_s = pipe_q[last_lp];

    for (genvar l = 0; l < 2; l++) begin : g_lane
        assign exc_eff[l] = out_s.exception[l] | io.exception_late_i[l];
        assign redir[l]   = (|exc_eff[l]) | (|out_s.special[l]);

        assign io.retire_exception_o[l] = retire_v[l] ? exc_eff[l] : '0;
        // An excepting op never reports its redirect flags.
        assign io.retire_special_o[l]   = (retire_v[l] & ~(|exc_eff[l])) ? out_s.special[l] : '0;
    end

    assign red0        = out_s.v[0] & redir[0];
    assign retire_v[0] = out_s.v[0];
    assign retire_v[1] = out_s.v[1] & ~red0;
    assign squash      = red0 | (retire_v[1] & redir[1]);
    assign kill        = io.flush_i | squash;

    assign io.retire_v_o       = retire_v;
    assign io.retire_queue_v_o = retire_v & out_s.queue_v;
    assign io.retire_data_o    = out_s.data;
    assign io.squash_o         = squash;

    always_comb begin
        pipe_d = pipe_q;
        pipe_d[0].v         = io.v_i;
        pipe_d[0].queue_v   = io.queue_v_i;
        pipe_d[0].exception = io.exception_i;
        pipe_d[0].special   = io.special_i;
        pipe_d[0].data      = io.data_i;
        for (int k = 1; k < retire_depth_p; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
        // The output entry is the commit point; everything behind it is younger.
        if (kill) begin
            for (int k = 0; k < retire_depth_p; k++) begin
                pipe_d[k].v = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

`ifdef BP_BE_RETIRE_STATS_EN
    logic [31:0] stat_pair_q, stat_single_q, stat_squash_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_pair_q   <= '0;
            stat_single_q <= '0;
            stat_squash_q <= '0;
        end else begin
            stat_pair_q   <= stat_pair_q   + {31'b0, &retire_v};
            stat_single_q <= stat_single_q + {31'b0, ^retire_v};
            stat_squash_q <= stat_squash_q + {31'b0, squash};
        end
    end

    assign stat_pair_o   = stat_pair_q;
    assign stat_single_o = stat_single_q;
    assign stat_squash_o = stat_squash_q;
`endif

endmodule

// File: tb/tb_bp_be_dual_retire_ctrl.sv
// Scoreboard bench for bp_be_dual_retire_ctrl: directed plan sequences then random traffic.
module tb_bp_be_dual_retire_ctrl;
    localparam int DEPTH = 2;
    localparam int DW    = 16;
    localparam int EW    = 4;
    localparam int SW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   last_kill = -100;
    bit   prev_rst = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bp_be_dual_retire_ctrl_if #(.dpath_width_p(DW), .exception_width_p(EW), .special_width_p(SW)) io_if ();

`ifdef BP_BE_RETIRE_STATS_EN
    logic [31:0] stat_pair, stat_single, stat_squash;
    int m_pair = 0, m_single = 0, m_sq = 0;
`endif

    bp_be_dual_retire_ctrl #(
        .retire_depth_p(DEPTH), .dpath_width_gp(DW),
        .exception_width_lp(EW), .special_width_lp(SW)
    ) dut (
        .clk_i(clk),
        .reset_i(rst),
        .io(io_if.slave)
`ifdef BP_BE_RETIRE_STATS_EN
        ,
        .stat_pair_o(stat_pair),
        .stat_single_o(stat_single),
        .stat_squash_o(stat_squash)
`endif
    );

    typedef struct {
        int                 cyc;
        logic [1:0]         v;
        logic [1:0]         qv;
        logic [1:0][EW-1:0] exc;
        logic [1:0][SW-1:0] sp;
        logic [1:0][DW-1:0] d;
    } ent_t;

    ent_t sbq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    endtask

    // One cycle of stimulus; the entry is logged with the cycle it was presented in.
    task automatic drive(input logic [1:0] v, input logic [EW-1:0] e0, input logic [EW-1:0] e1,
                         input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                         input logic [EW-1:0] l0, input logic [EW-1:0] l1,
                         input logic fl, input logic r);
        ent_t e;
        e.cyc = cyc;
        e.v   = v;
        e.qv  = 2'($urandom);
        e.exc[0] = e0; e.exc[1] = e1;
        e.sp[0]  = s0; e.sp[1]  = s1;
        e.d[0] = DW'($urandom); e.d[1] = DW'($urandom);
        io_if.v_i = e.v;
        io_if.queue_v_i = e.qv;
        io_if.exception_i = e.exc;
        io_if.special_i = e.sp;
        io_if.data_i = e.d;
        io_if.exception_late_i[0] = l0;
        io_if.exception_late_i[1] = l1;
        io_if.flush_i = fl;
        rst = r;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [EW-1:0] rnd_exc(input int odds);
        return ($urandom_range(0, odds - 1) == 0) ? EW'($urandom_range(1, (1 << EW) - 1)) : '0;
    endfunction

    function automatic logic [SW-1:0] rnd_sp(input int odds);
        return ($urandom_range(0, odds - 1) == 0) ? SW'($urandom_range(1, (1 << SW) - 1)) : '0;
    endfunction

    // Monitor: an entry presented in cycle e retires in cycle e+DEPTH unless a
    // squash, flush or reset happened in any cycle from e up to e+DEPTH-1.
    always @(negedge clk) begin
        ent_t               e;
        bit                 have;
        logic [1:0]         ev, erv, eqv;
        logic [1:0][EW-1:0] ee, eexc;
        logic [1:0][SW-1:0] esp;
        logic [1:0]         red;
        logic               esq;
        have = 1'b0;
        while (sbq.size() > 0 && sbq[0].cyc < cyc - DEPTH) void'(sbq.pop_front());
        if (sbq.size() > 0 && sbq[0].cyc == cyc - DEPTH) begin
            e = sbq.pop_front();
            have = (last_kill < e.cyc);
        end
        if (rst) begin
            last_kill = cyc;
            prev_rst = 1'b1;
`ifdef BP_BE_RETIRE_STATS_EN
            m_pair = 0; m_single = 0; m_sq = 0;
`endif
        end else begin
            ev = have ? e.v : 2'b00;
            for (int l = 0; l < 2; l++) begin
                ee[l]  = (have ? e.exc[l] : '0) | io_if.exception_late_i[l];
                red[l] = (ee[l] != 0) || (have && e.sp[l] != 0);
            end
            erv[0] = ev[0];
            erv[1] = ev[1] && !(ev[0] && red[0]);
            esq = (ev[0] && red[0]) || (erv[1] && red[1]);
            for (int l = 0; l < 2; l++) begin
                eqv[l]  = erv[l] && e.qv[l];
                eexc[l] = erv[l] ? ee[l] : '0;
                esp[l]  = (erv[l] && ee[l] == 0) ? e.sp[l] : '0;
            end
            chk("retire_v", 64'(io_if.retire_v_o), 64'(erv));
            chk("retire_queue_v", 64'(io_if.retire_queue_v_o), 64'(eqv));
            chk("retire_exception", 64'(io_if.retire_exception_o), 64'(eexc));
            chk("retire_special", 64'(io_if.retire_special_o), 64'(esp));
            chk("squash", 64'(io_if.squash_o), 64'(esq));
            for (int l = 0; l < 2; l++)
                if (erv[l]) chk("retire_data", 64'(io_if.retire_data_o[l]), 64'(e.d[l]));
            if (prev_rst) chk("data_after_reset", 64'(io_if.retire_data_o), 64'(0));
`ifdef BP_BE_RETIRE_STATS_EN
            chk("stat_pair", 64'(stat_pair), 64'(m_pair));
            chk("stat_single", 64'(stat_single), 64'(m_single));
            chk("stat_squash", 64'(stat_squash), 64'(m_sq));
            m_pair   += (erv == 2'b11) ? 1 : 0;
            m_single += (erv == 2'b01 || erv == 2'b10) ? 1 : 0;
            m_sq     += esq ? 1 : 0;
`endif
            if (io_if.flush_i || esq) last_kill = cyc;
            prev_rst = 1'b0;
        end
    end

    initial begin
        drive(2'b00, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        drive(2'b00, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        drive(2'b00, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        idle(2);
        // Back-to-back clean pairs
        for (int i = 0; i < 4; i++) drive(2'b11, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        idle(3);
        // Lane 0 early exception followed by two pairs that must never retire
        drive(2'b11, 4'h2, '0, 2'b01, '0, '0, '0, 1'b0, 1'b0);
        drive(2'b11, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        drive(2'b11, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        idle(3);
        // Late exception arriving at the output stage
        drive(2'b11, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        idle(1);
        drive(2'b00, '0, '0, '0, '0, 4'h1, '0, 1'b0, 1'b0);
        idle(2);
        // Lane 1 alone
        drive(2'b10, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        idle(3);
        // Flush in the third cycle of a burst
        drive(2'b11, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        drive(2'b11, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        drive(2'b11, '0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
        idle(3);
        // Reset with both stages full
        drive(2'b11, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        drive(2'b11, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        drive(2'b11, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        idle(3);
        // Random traffic with occasional redirects, flushes and resets
        for (int i = 0; i < 1500; i++) begin
            drive(2'($urandom), rnd_exc(8), rnd_exc(8), rnd_sp(8), rnd_sp(8),
                  rnd_exc(16), rnd_exc(16), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 199) == 0));
        end
        idle(5);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
